histogram_accumulator: RTL and testbench

Builds a 256-bin, 20-bit luminance histogram from the 8-bit camera pixel stream, one pixel per clock. At end of frame it scans the bins to find the peak count and the median bin. It presents the completed histogram, peak and median to the histogram display stage through a registered read port. Two RAM banks are used ping-pong, so the display stage always reads a stable, complete frame while the next frame accumulates.

---
 rtl/histogram_accumulator.sv | 208 ++++++++++++++++++++
 tb/tb_histogram_accumulator.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/histogram_accumulator.sv
// histogram_accumulator
//   Builds a 256-bin luminance histogram (CW-bit saturating counts) from a
//   one-pixel-per-clock stream. At end of frame the build bank is scanned for
//   the peak count and the median bin, then the banks swap so the display
//   side always sees a complete, stable frame.
//
// Ports
//   iClk, iRst_n         clock, async active-low reset
//   iFrameStart/iFrameEnd single-cycle frame delimiters
//   iValid, iPixel       pixel stream (pixel value is the bin index)
//   iRdAddr -> oRdData   display-bank read, 1-cycle latency
//   oMaxValue            peak bin count of last completed frame
//   oThreshPoint         median bin of last completed frame
//   oFrameDone           pulse when a new histogram becomes visible
//   oBusy                high outside IDLE/ACCUM
module histogram_accumulator #(
  parameter int CW = 20
) (
  input  logic          iClk,
  input  logic          iRst_n,
  input  logic          iFrameStart,
  input  logic          iFrameEnd,
  input  logic          iValid,
  input  logic [7:0]    iPixel,
  input  logic [7:0]    iRdAddr,
  output logic [CW-1:0] oRdData,
  output logic [CW-1:0] oMaxValue,
  output logic [7:0]    oThreshPoint,
  output logic          oFrameDone,
  output logic          oBusy
);

  localparam int BINS = 256;
  localparam logic [CW-1:0] CMAX = '1;

  typedef enum logic [2:0] {
    S_CLEAR, S_IDLE, S_ACCUM, S_FLUSH, S_SCAN, S_SWAP
  } state_e;

  state_e        state_q;
  logic          bsel_q;       // build bank = bsel_q, display bank = ~bsel_q
  logic          clr_both_q;   // reset clear wipes both banks at once
  logic [8:0]    cnt_q;        // shared CLEAR / FLUSH / SCAN counter
  logic [CW-1:0] tot_q;        // accepted pixels this frame (saturating)

  // Increment pipeline: [0] read issued, [1] sum ready to write, [2] just written
  logic [2:0]    vld_pipe_q;
  logic [7:0]    a1_q, a2_q, a3_q;
  logic [CW-1:0] d2_q, d3_q;

  logic [CW:0]   cum_q;
  logic [CW-1:0] max_q, res_max_q, omax_q;
  logic [7:0]    med_q, res_med_q, othr_q;
  logic          found_q, ofd_q;

  logic [CW-1:0] mem0 [BINS];
  logic [CW-1:0] mem1 [BINS];
  logic [CW-1:0] brd_q;        // build-bank port A read data
  logic [CW-1:0] rd_q;         // display-bank read data

  // ---------------------------------------------------------------- datapath
  logic          pix_acc;
  logic [CW-1:0] base, inc;
  logic [7:0]    rd_addr_a, wa_b, scan_bin;
  logic [CW-1:0] wd_b;
  logic          we_b, we0, we1;
  logic [8:0]    cnt_m1;
  logic [CW+1:0] cum_sum;
  logic [CW:0]   cum_nx;
  logic          med_hit, scan_dv;

  assign pix_acc = (state_q == S_ACCUM) && iValid;

  // A bin read from RAM may be stale if either of the two preceding pixels
  // hit the same bin: one is about to be written, one was written on the
  // same edge as the read. Youngest value wins.
  always_comb begin
    base = brd_q;
    if (vld_pipe_q[1] && a2_q == a1_q)      base = d2_q;
    else if (vld_pipe_q[2] && a3_q == a1_q) base = d3_q;
    inc = (base == CMAX) ? CMAX : base + 1'b1;
  end

  assign rd_addr_a = (state_q == S_SCAN) ? cnt_q[7:0] : iPixel;
  assign we_b      = (state_q == S_CLEAR) || vld_pipe_q[1];
  assign wa_b      = (state_q == S_CLEAR) ? cnt_q[7:0] : a2_q;
  assign wd_b      = (state_q == S_CLEAR) ? '0 : d2_q;
  assign we0       = we_b && (!bsel_q || clr_both_q);
  assign we1       = we_b && ( bsel_q || clr_both_q);

  // Scan: read data for bin cnt-1 arrives while cnt is 1..256.
  assign cnt_m1   = cnt_q - 9'd1;
  assign scan_bin = cnt_m1[7:0];
  assign scan_dv  = (state_q == S_SCAN) && (cnt_q != 9'd0) && (cnt_q <= 9'd256);
  assign cum_sum  = {1'b0, cum_q} + {2'b00, brd_q};
  assign cum_nx   = cum_sum[CW+1] ? {(CW+1){1'b1}} : cum_sum[CW:0];
  assign med_hit  = {cum_nx, 1'b0} >= {2'b00, tot_q};

  always_ff @(posedge iClk) begin
    if (we0) mem0[wa_b] <= wd_b;
    if (we1) mem1[wa_b] <= wd_b;
    brd_q <= bsel_q ? mem1[rd_addr_a] : mem0[rd_addr_a];
    rd_q  <= bsel_q ? mem0[iRdAddr]   : mem1[iRdAddr];
  end

  // --------------------------------------------------------------- control
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q    <= S_CLEAR;
      bsel_q     <= 1'b0;
      clr_both_q <= 1'b1;
      cnt_q      <= '0;
      tot_q      <= '0;
      vld_pipe_q <= '0;
      a1_q       <= '0;
      a2_q       <= '0;
      a3_q       <= '0;
      d2_q       <= '0;
      d3_q       <= '0;
      cum_q      <= '0;
      max_q      <= '0;
      med_q      <= '0;
      found_q    <= 1'b0;
      res_max_q  <= '0;
      res_med_q  <= '0;
      omax_q     <= '0;
      othr_q     <= '0;
      ofd_q      <= 1'b0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[1:0], pix_acc};
      a1_q       <= iPixel;
      a2_q       <= a1_q;
      d2_q       <= inc;
      a3_q       <= a2_q;
      d3_q       <= d2_q;
      ofd_q      <= 1'b0;

      case (state_q)
        S_CLEAR: begin
          cnt_q <= cnt_q + 9'd1;
          if (cnt_q == 9'd255) begin
            cnt_q      <= '0;
            clr_both_q <= 1'b0;
            state_q    <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (iFrameStart) begin
            tot_q   <= '0;
            state_q <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (pix_acc && tot_q != CMAX) tot_q <= tot_q + 1'b1;
          if (iFrameEnd) begin
            cnt_q   <= '0;
            state_q <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          // two edges let the last pixel reach the RAM
          cnt_q <= cnt_q + 9'd1;
          if (cnt_q == 9'd1) begin
            cnt_q   <= '0;
            cum_q   <= '0;
            max_q   <= '0;
            med_q   <= '0;
            found_q <= 1'b0;
            state_q <= S_SCAN;
          end
        end
        S_SCAN: begin
          cnt_q <= cnt_q + 9'd1;
          if (scan_dv) begin
            cum_q <= cum_nx;
            if (brd_q > max_q) max_q <= brd_q;
            if (!found_q && med_hit) begin
              med_q   <= scan_bin;
              found_q <= 1'b1;
            end
          end
          if (cnt_q == 9'd257) begin
            res_max_q <= (tot_q == '0) ? '0 : max_q;
            res_med_q <= (tot_q == '0) ? '0 : med_q;
            cnt_q     <= '0;
            state_q   <= S_SWAP;
          end
        end
        S_SWAP: begin
          omax_q  <= res_max_q;
          othr_q  <= res_med_q;
          ofd_q   <= 1'b1;
          bsel_q  <= ~bsel_q;
          cnt_q   <= '0;
          state_q <= S_CLEAR;
        end
        default: state_q <= S_CLEAR;
      endcase
    end
  end

  assign oRdData      = rd_q;
  assign oMaxValue    = omax_q;
  assign oThreshPoint = othr_q;
  assign oFrameDone   = ofd_q;
  assign oBusy        = (state_q != S_IDLE) && (state_q != S_ACCUM);

endmodule

// File: tb/tb_histogram_accumulator.sv
// Bench for histogram_accumulator: directed frames, a per-bin reference
// histogram per bank, and a per-cycle compare of all outputs.
module tb_histogram_accumulator;

  logic        iClk = 1'b0, iRst_n = 1'b0;
  logic        iFrameStart = 1'b0, iFrameEnd = 1'b0, iValid = 1'b0;
  logic [7:0]  iPixel = '0, iRdAddr = '0;
  logic [19:0] oRdData, oMaxValue;
  logic [7:0]  oThreshPoint;
  logic        oFrameDone, oBusy;

  histogram_accumulator #(.CW(20)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iFrameStart(iFrameStart), .iFrameEnd(iFrameEnd),
    .iValid(iValid), .iPixel(iPixel), .iRdAddr(iRdAddr), .oRdData(oRdData),
    .oMaxValue(oMaxValue), .oThreshPoint(oThreshPoint), .oFrameDone(oFrameDone),
    .oBusy(oBusy)
  );

  always #5 iClk = ~iClk;

  int cyc = 0;
  always @(posedge iClk) cyc++;

  int total = 0, bad = 0;
  int build[256], disp[256];
  int m_total = 0, exp_max = 0, exp_med = 0;
  bit chk_en = 0, pend = 0;
  int eof_c = 0;
  logic [7:0] prev_addr = '0;
  int fd_rd = -1, fd_rd_next = -1;
  logic [7:0] pq[$];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: peak and median computed from the finished histogram.
  function automatic void model_swap();
    int cum, mx, md;
    bit found;
    cum = 0; mx = 0; md = 0; found = 0;
    for (int b = 0; b < 256; b++) begin
      if (build[b] > mx) mx = build[b];
      cum += build[b];
      if (!found && 2 * cum >= m_total) begin md = b; found = 1; end
    end
    exp_max = mx;
    exp_med = md;
    for (int b = 0; b < 256; b++) begin disp[b] = build[b]; build[b] = 0; end
    m_total = 0;
  endfunction

  always @(negedge iClk) begin
    if (chk_en) begin
      chk("rd_data", int'(oRdData), disp[prev_addr]);
      if (pend && cyc == eof_c + 261) model_swap();
      chk("frame_done", int'(oFrameDone), int'(pend && cyc == eof_c + 261));
      chk("busy", int'(oBusy), int'(pend && cyc >= eof_c && cyc < eof_c + 517));
      chk("max_value", int'(oMaxValue), exp_max);
      chk("thresh_point", int'(oThreshPoint), exp_med);
      if (pend && cyc >= eof_c + 517) pend = 0;
    end
    prev_addr = iRdAddr;
  end

  task automatic step();
    @(posedge iClk); #1;
  endtask

  task automatic acc(input logic [7:0] p);
    if (build[p] < 1048575) build[p]++;
    m_total++;
  endtask

  task automatic rd_check(input logic [7:0] a, input int exp, input string nm);
    iRdAddr = a;
    step();
    chk(nm, int'(oRdData), exp);
  endtask

  // Sends pq as one frame, then waits for the swap and the return to IDLE.
  // With junk set, pixels and frame pulses are thrown in during SCAN and CLEAR.
  task automatic run_frame(input bit junk);
    int lat, n, rel;
    bit seen;
    iFrameStart = 1; step(); iFrameStart = 0;
    if (pq.size() == 0) begin
      iFrameEnd = 1; eof_c = cyc + 1; pend = 1; step();
    end else begin
      for (int i = 0; i < pq.size(); i++) begin
        iValid = 1; iPixel = pq[i]; acc(pq[i]);
        if (i == pq.size() - 1) begin iFrameEnd = 1; eof_c = cyc + 1; pend = 1; end
        step();
      end
    end
    iValid = 0; iFrameEnd = 0;
    seen = 0; lat = -1; n = 0;
    while (n < 800 && !(seen && !oBusy)) begin
      rel = cyc - eof_c;
      iValid      = junk && ((rel >= 10 && rel < 110) || (rel >= 300 && rel < 400));
      iPixel      = (rel < 200) ? 8'd9 : 8'd3;
      iFrameStart = junk && rel == 50;
      iFrameEnd   = junk && rel == 60;
      step(); n++;
      if (oFrameDone && !seen) begin seen = 1; lat = cyc - eof_c; fd_rd = int'(oRdData); end
      else if (seen && cyc == eof_c + 262) fd_rd_next = int'(oRdData);
    end
    iValid = 0; iFrameStart = 0; iFrameEnd = 0;
    chk("fd_latency", lat, 261);
    chk("idle_after_frame", int'(oBusy), 0);
  endtask

  initial begin
    int n, fd_cnt;
    for (int b = 0; b < 256; b++) begin build[b] = 0; disp[b] = 0; end

    // ---- reset
    repeat (3) @(posedge iClk);
    #1;
    chk("rst_max", int'(oMaxValue), 0);
    chk("rst_thresh", int'(oThreshPoint), 0);
    chk("rst_done", int'(oFrameDone), 0);
    chk("rst_busy", int'(oBusy), 1);
    @(negedge iClk); iRst_n = 1;
    n = 0;
    while (oBusy && n < 400) begin step(); n++; end
    chk("reset_clear_cycles", n, 256);
    chk_en = 1;
    rd_check(8'd0, 0, "rst_bin0");
    rd_check(8'd255, 0, "rst_bin255");

    // ---- uniform frame
    pq.delete();
    for (int i = 0; i < 256; i++) pq.push_back(8'(i));
    run_frame(0);
    chk("uni_max", int'(oMaxValue), 1);
    chk("uni_med", int'(oThreshPoint), 127);
    rd_check(8'd0, 1, "uni_bin0");
    rd_check(8'd255, 1, "uni_bin255");

    // ---- same-bin hazards: 42 x1000, then 5,5,7,5,7,7 x100 (total 1600,
    // cumulative 300 at bin 5, 600 at bin 7, 1600 at bin 42)
    pq.delete();
    for (int i = 0; i < 1000; i++) pq.push_back(8'd42);
    for (int r = 0; r < 100; r++) begin
      pq.push_back(8'd5); pq.push_back(8'd5); pq.push_back(8'd7);
      pq.push_back(8'd5); pq.push_back(8'd7); pq.push_back(8'd7);
    end
    run_frame(0);
    chk("haz_max", int'(oMaxValue), 1000);
    chk("haz_med", int'(oThreshPoint), 42);
    rd_check(8'd42, 1000, "haz_bin42");
    rd_check(8'd5, 300, "haz_bin5");
    rd_check(8'd7, 300, "haz_bin7");
    rd_check(8'd6, 0, "haz_bin6");

    // ---- empty frame
    pq.delete();
    run_frame(0);
    chk("empty_max", int'(oMaxValue), 0);
    chk("empty_med", int'(oThreshPoint), 0);
    rd_check(8'd42, 0, "empty_bin42");

    // ---- ping-pong: A = 50 x 200, B = 40 x 10, reading bin 200 throughout
    pq.delete();
    for (int i = 0; i < 50; i++) pq.push_back(8'd200);
    run_frame(0);
    iRdAddr = 8'd200;
    pq.delete();
    for (int i = 0; i < 40; i++) pq.push_back(8'd10);
    run_frame(0);
    chk("pp_read_at_done", fd_rd, 50);
    chk("pp_read_after_done", fd_rd_next, 0);
    rd_check(8'd10, 40, "pp_bin10");
    chk("pp_max", int'(oMaxValue), 40);
    chk("pp_med", int'(oThreshPoint), 10);

    // ---- drops during SCAN/CLEAR
    pq.delete();
    pq.push_back(8'd3); pq.push_back(8'd3); pq.push_back(8'd3); pq.push_back(8'd9);
    run_frame(1);
    chk("drop_max", int'(oMaxValue), 3);
    chk("drop_med", int'(oThreshPoint), 3);
    rd_check(8'd9, 1, "drop_bin9");
    rd_check(8'd3, 3, "drop_bin3");
    pq.delete();
    pq.push_back(8'd1); pq.push_back(8'd2);
    run_frame(0);
    chk("next_max", int'(oMaxValue), 1);
    chk("next_med", int'(oThreshPoint), 1);
    rd_check(8'd3, 0, "next_bin3");
    rd_check(8'd9, 0, "next_bin9");
    rd_check(8'd2, 1, "next_bin2");

    // ---- reset in the middle of ACCUM
    iFrameStart = 1; step(); iFrameStart = 0;
    for (int i = 0; i < 20; i++) begin iValid = 1; iPixel = 8'd77; step(); end
    chk_en = 0;
    iRst_n = 0; iValid = 0;
    step(); step();
    pend = 0;
    for (int b = 0; b < 256; b++) begin build[b] = 0; disp[b] = 0; end
    m_total = 0; exp_max = 0; exp_med = 0;
    iRst_n = 1;
    n = 0;
    while (oBusy && n < 400) begin step(); n++; end
    chk("abort_clear_cycles", n, 256);
    chk_en = 1;
    fd_cnt = 0;
    for (int i = 0; i < 300; i++) begin step(); if (oFrameDone) fd_cnt++; end
    chk("abort_no_done", fd_cnt, 0);
    rd_check(8'd77, 0, "abort_bin77");
    rd_check(8'd200, 0, "abort_bin200");
    chk("abort_max", int'(oMaxValue), 0);

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
